// File: rtl/udp_pkg.sv
// Shared register map, field positions, AXI response codes and FSM states
// for the UDP transmit configuration slave.
package udp_pkg;

    localparam int unsigned REG_IDX_W = 3;

    localparam logic [5:0] OFS_CTRL     = 6'h00;
    localparam logic [5:0] OFS_STATUS   = 6'h04;
    localparam logic [5:0] OFS_SRC_IP   = 6'h08;
    localparam logic [5:0] OFS_DST_IP   = 6'h0C;
    localparam logic [5:0] OFS_PORTS    = 6'h10;
    localparam logic [5:0] OFS_LEN      = 6'h14;
    localparam logic [5:0] OFS_TX_COUNT = 6'h18;
    localparam logic [5:0] OFS_ID       = 6'h1C;

    localparam logic [REG_IDX_W-1:0] IDX_CTRL     = OFS_CTRL[4:2];
    localparam logic [REG_IDX_W-1:0] IDX_STATUS   = OFS_STATUS[4:2];
    localparam logic [REG_IDX_W-1:0] IDX_SRC_IP   = OFS_SRC_IP[4:2];
    localparam logic [REG_IDX_W-1:0] IDX_DST_IP   = OFS_DST_IP[4:2];
    localparam logic [REG_IDX_W-1:0] IDX_PORTS    = OFS_PORTS[4:2];
    localparam logic [REG_IDX_W-1:0] IDX_LEN      = OFS_LEN[4:2];
    localparam logic [REG_IDX_W-1:0] IDX_TX_COUNT = OFS_TX_COUNT[4:2];
    localparam logic [REG_IDX_W-1:0] IDX_ID       = OFS_ID[4:2];

    localparam int unsigned CTRL_START_BIT  = 0;
    localparam int unsigned CTRL_ENABLE_BIT = 1;
    localparam int unsigned STATUS_BUSY_BIT = 0;
    localparam int unsigned STATUS_DONE_BIT = 1;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    // Merge new write data into an old register value per byte strobe.
    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/udp_cfg_axil_slave.sv
// AXI4-Lite register slave holding the UDP transmit header configuration,
// the start/done handshake with the transmitter and a sent-packet counter.
module udp_cfg_axil_slave
    import udp_pkg::*;
#(
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned DATA_W   = 32,
    parameter logic [31:0] ID_VALUE = 32'h5544_5001
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [DATA_W-1:0]   s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready,
    output logic                tx_start,
    input  logic                tx_busy,
    input  logic                tx_done,
    output logic [31:0]         src_ip,
    output logic [31:0]         dst_ip,
    output logic [15:0]         src_port,
    output logic [15:0]         dst_port,
    output logic [15:0]         payload_len
);

    wr_state_t             r_wstate;
    rd_state_t             r_rstate;
    logic                  r_awready, r_wready, r_arready;
    logic                  r_aw_ok, r_w_ok;
    logic [REG_IDX_W-1:0]  r_wr_idx;
    logic                  r_wr_mapped;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W/8-1:0]   r_wstrb;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic                  r_rvalid;
    logic [1:0]            r_rresp;
    logic [DATA_W-1:0]     r_rdata;
    logic                  r_tx_start;
    logic                  r_enable, r_done;
    logic [31:0]           r_src_ip, r_dst_ip, r_ports, r_tx_count;
    logic [15:0]           r_len;

    logic                  w_commit, w_start, w_done_clr;
    logic                  w_wr_mapped, w_rd_mapped;
    logic [REG_IDX_W-1:0]  w_rd_idx;
    logic [DATA_W-1:0]     w_rd_data;
    logic                  w_unused;

    assign w_wr_mapped = (s_axi_awaddr[ADDR_W-1:5] == '0);
    assign w_rd_mapped = (s_axi_araddr[ADDR_W-1:5] == '0);
    assign w_rd_idx    = s_axi_araddr[4:2];
    assign w_unused    = &{1'b0, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // A start is honoured only when enabled (stored or same write) and the transmitter is idle.
    assign w_commit   = (r_wstate == W_IDLE) && r_aw_ok && r_w_ok;
    assign w_start    = w_commit && r_wr_mapped && (r_wr_idx == IDX_CTRL) && r_wstrb[0]
                        && r_wdata[CTRL_START_BIT]
                        && (r_enable || r_wdata[CTRL_ENABLE_BIT]) && !tx_busy;
    assign w_done_clr = w_commit && r_wr_mapped && (r_wr_idx == IDX_STATUS) && r_wstrb[0]
                        && r_wdata[STATUS_DONE_BIT];

    always_comb begin
        w_rd_data = '0;
        if (w_rd_mapped) begin
            case (w_rd_idx)
                IDX_CTRL:     w_rd_data[CTRL_ENABLE_BIT] = r_enable;
                IDX_STATUS: begin
                    w_rd_data[STATUS_BUSY_BIT] = tx_busy;
                    w_rd_data[STATUS_DONE_BIT] = r_done;
                end
                IDX_SRC_IP:   w_rd_data = r_src_ip;
                IDX_DST_IP:   w_rd_data = r_dst_ip;
                IDX_PORTS:    w_rd_data = r_ports;
                IDX_LEN:      w_rd_data = DATA_W'(r_len);
                IDX_TX_COUNT: w_rd_data = r_tx_count;
                IDX_ID:       w_rd_data = ID_VALUE;
                default:      w_rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstate    <= W_IDLE;
            r_rstate    <= R_IDLE;
            r_awready   <= 1'b0;
            r_wready    <= 1'b0;
            r_arready   <= 1'b0;
            r_aw_ok     <= 1'b0;
            r_w_ok      <= 1'b0;
            r_wr_idx    <= '0;
            r_wr_mapped <= 1'b0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_bvalid    <= 1'b0;
            r_bresp     <= AXI_RESP_OKAY;
            r_rvalid    <= 1'b0;
            r_rresp     <= AXI_RESP_OKAY;
            r_rdata     <= '0;
            r_tx_start  <= 1'b0;
            r_enable    <= 1'b0;
            r_done      <= 1'b0;
            r_src_ip    <= '0;
            r_dst_ip    <= '0;
            r_ports     <= '0;
            r_len       <= '0;
            r_tx_count  <= '0;
        end else begin
            r_tx_start <= w_start;
            if (tx_done) begin
                r_tx_count <= r_tx_count + 32'd1;
                r_done     <= 1'b1;
            end else if (w_done_clr) begin
                r_done <= 1'b0;
            end

            case (r_wstate)
                W_IDLE: begin
                    if (w_commit) begin
                        if (r_wr_mapped) begin
                            case (r_wr_idx)
                                IDX_CTRL:   if (r_wstrb[0]) r_enable <= r_wdata[CTRL_ENABLE_BIT];
                                IDX_SRC_IP: r_src_ip <= apply_strb(r_src_ip, r_wdata, r_wstrb);
                                IDX_DST_IP: r_dst_ip <= apply_strb(r_dst_ip, r_wdata, r_wstrb);
                                IDX_PORTS:  r_ports  <= apply_strb(r_ports, r_wdata, r_wstrb);
                                IDX_LEN:    r_len    <= 16'(apply_strb({16'h0, r_len}, r_wdata, r_wstrb));
                                default: ;
                            endcase
                        end
                        r_bresp  <= r_wr_mapped ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                        r_bvalid <= 1'b1;
                        r_aw_ok  <= 1'b0;
                        r_w_ok   <= 1'b0;
                        r_wstate <= W_RESP;
                    end else begin
                        if (!r_aw_ok) begin
                            if (r_awready && s_axi_awvalid) begin
                                r_wr_idx    <= s_axi_awaddr[4:2];
                                r_wr_mapped <= w_wr_mapped;
                                r_aw_ok     <= 1'b1;
                                r_awready   <= 1'b0;
                            end else begin
                                r_awready <= 1'b1;
                            end
                        end
                        if (!r_w_ok) begin
                            if (r_wready && s_axi_wvalid) begin
                                r_wdata  <= s_axi_wdata;
                                r_wstrb  <= s_axi_wstrb;
                                r_w_ok   <= 1'b1;
                                r_wready <= 1'b0;
                            end else begin
                                r_wready <= 1'b1;
                            end
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase

            // Read data is captured at the AR handshake, so a coinciding write commit is not yet visible.
            case (r_rstate)
                R_IDLE: begin
                    if (r_arready && s_axi_arvalid) begin
                        r_rdata   <= w_rd_data;
                        r_rresp   <= w_rd_mapped ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                        r_rvalid  <= 1'b1;
                        r_arready <= 1'b0;
                        r_rstate  <= R_DATA;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rdata   = r_rdata;
    assign tx_start      = r_tx_start;
    assign src_ip        = r_src_ip;
    assign dst_ip        = r_dst_ip;
    assign src_port      = r_ports[31:16];
    assign dst_port      = r_ports[15:0];
    assign payload_len   = r_len;

endmodule

// File: tb/tb_udp_cfg_axil_slave.sv
// Directed self-checking bench for udp_cfg_axil_slave.
module tb_udp_cfg_axil_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [5:0]  s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic        tx_start;
    logic        tx_busy;
    logic        tx_done;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] payload_len;

    int n_checks = 0;
    int n_errors = 0;
    int start_total = 0;

    udp_cfg_axil_slave dut (
        .clk          (clk),
        .rst          (rst),
        .s_axi_awaddr (s_axi_awaddr),
        .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_wdata  (s_axi_wdata),
        .s_axi_wstrb  (s_axi_wstrb),
        .s_axi_wvalid (s_axi_wvalid),
        .s_axi_wready (s_axi_wready),
        .s_axi_bresp  (s_axi_bresp),
        .s_axi_bvalid (s_axi_bvalid),
        .s_axi_bready (s_axi_bready),
        .s_axi_araddr (s_axi_araddr),
        .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rdata  (s_axi_rdata),
        .s_axi_rresp  (s_axi_rresp),
        .s_axi_rvalid (s_axi_rvalid),
        .s_axi_rready (s_axi_rready),
        .tx_start     (tx_start),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done),
        .src_ip       (src_ip),
        .dst_ip       (dst_ip),
        .src_port     (src_port),
        .dst_port     (dst_port),
        .payload_len  (payload_len)
    );

    always #5 clk = ~clk;

    // Total cycles tx_start was seen high.
    always @(posedge clk) if (tx_start) start_total <= start_total + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic axi_write(input logic [5:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        int   n;
        logic aw_hs, w_hs;
        s_axi_awaddr  = addr;
        s_axi_awvalid = 1'b1;
        s_axi_wdata   = data;
        s_axi_wstrb   = strb;
        s_axi_wvalid  = 1'b1;
        n = 0;
        while ((s_axi_awvalid || s_axi_wvalid) && n < 50) begin
            aw_hs = s_axi_awvalid && s_axi_awready;
            w_hs  = s_axi_wvalid && s_axi_wready;
            tick(1);
            if (aw_hs) s_axi_awvalid = 1'b0;
            if (w_hs)  s_axi_wvalid  = 1'b0;
            n++;
        end
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b1;
        while (!s_axi_bvalid && n < 50) begin
            tick(1);
            n++;
        end
        check("wr_timeout", 32'(n >= 50), 32'd0);
        resp = s_axi_bresp;
        tick(1);
        s_axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [5:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        n = 0;
        while (!s_axi_arready && n < 50) begin
            tick(1);
            n++;
        end
        tick(1);
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b1;
        while (!s_axi_rvalid && n < 50) begin
            tick(1);
            n++;
        end
        check("rd_timeout", 32'(n >= 50), 32'd0);
        data = s_axi_rdata;
        resp = s_axi_rresp;
        tick(1);
        s_axi_rready = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [5:0] addr,
                            input logic [31:0] exp_data, input logic [1:0] exp_resp);
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(addr, d, r);
        check(tag, d, exp_data);
        check({tag, "_resp"}, 32'(r), 32'(exp_resp));
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] rsp;
        int         s0;
        rst = 1'b1;
        s_axi_awaddr = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata  = '0; s_axi_wstrb   = '0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b0;
        s_axi_araddr = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
        tx_busy = 1'b0; tx_done = 1'b0;
        tick(3);

        check("rst_awready", 32'(s_axi_awready), 32'd0);
        check("rst_wready",  32'(s_axi_wready),  32'd0);
        check("rst_arready", 32'(s_axi_arready), 32'd0);
        check("rst_bvalid",  32'(s_axi_bvalid),  32'd0);
        check("rst_rvalid",  32'(s_axi_rvalid),  32'd0);
        check("rst_tx_start", 32'(tx_start),     32'd0);
        check("rst_resps", 32'({s_axi_bresp, s_axi_rresp}), 32'd0);

        rst = 1'b0;
        tick(1);
        check("awready_after_rst", 32'(s_axi_awready), 32'd1);
        check("wready_after_rst",  32'(s_axi_wready),  32'd1);
        check("arready_after_rst", 32'(s_axi_arready), 32'd1);

        rd_check("id", 6'h1C, 32'h5544_5001, 2'b00);

        // AW first, W three cycles later, response the cycle after W
        s_axi_awaddr = 6'h08; s_axi_awvalid = 1'b1;
        tick(1);
        s_axi_awvalid = 1'b0;
        check("aw_latched_awready", 32'(s_axi_awready), 32'd0);
        tick(2);
        s_axi_wdata = 32'hC0A8_0001; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        tick(1);
        s_axi_wvalid = 1'b0;
        check("bvalid_t3", 32'(s_axi_bvalid), 32'd0);
        tick(1);
        check("bvalid_t4", 32'(s_axi_bvalid), 32'd1);
        check("bresp_t4", 32'(s_axi_bresp), 32'd0);
        check("src_ip_t4", src_ip, 32'hC0A8_0001);
        s_axi_bready = 1'b1;
        tick(1);
        s_axi_bready = 1'b0;
        rd_check("src_ip_rb", 6'h08, 32'hC0A8_0001, 2'b00);
        rd_check("addr_lsb_ignored", 6'h0B, 32'hC0A8_0001, 2'b00);

        // Start pulse gating
        s0 = start_total;
        axi_write(6'h00, 32'h0, 4'hF, rsp);
        axi_write(6'h00, 32'h1, 4'hF, rsp);
        check("start_dropped_disabled", 32'(start_total - s0), 32'd0);
        s0 = start_total;
        axi_write(6'h00, 32'h3, 4'hF, rsp);
        check("start_pulse_1cyc", 32'(start_total - s0), 32'd1);
        check("ctrl_bresp", 32'(rsp), 32'd0);
        tx_busy = 1'b1;
        s0 = start_total;
        axi_write(6'h00, 32'h3, 4'hF, rsp);
        check("start_dropped_busy", 32'(start_total - s0), 32'd0);
        tx_busy = 1'b0;
        rd_check("ctrl_rb", 6'h00, 32'h2, 2'b00);

        // DONE and TX_COUNT
        repeat (3) begin
            tx_done = 1'b1;
            tick(1);
            tx_done = 1'b0;
            tick(1);
        end
        rd_check("status_done", 6'h04, 32'h2, 2'b00);
        rd_check("tx_count3", 6'h18, 32'd3, 2'b00);
        tx_busy = 1'b1;
        rd_check("status_busy", 6'h04, 32'h3, 2'b00);
        tx_busy = 1'b0;
        axi_write(6'h04, 32'h2, 4'hF, rsp);
        rd_check("status_w1c", 6'h04, 32'h0, 2'b00);

        // W1C commit in the same cycle as tx_done
        s_axi_awaddr = 6'h04; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'h2; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        tick(1);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
        check("w1c_vs_done_bvalid", 32'(s_axi_bvalid), 32'd1);
        s_axi_bready = 1'b1;
        tick(1);
        s_axi_bready = 1'b0;
        rd_check("status_done_wins", 6'h04, 32'h2, 2'b00);
        rd_check("tx_count4", 6'h18, 32'd4, 2'b00);

        // Unmapped window
        rd_check("unmapped_rd", 6'h24, 32'h0, 2'b10);
        axi_write(6'h24, 32'hFFFF_FFFF, 4'hF, rsp);
        check("unmapped_wr_bresp", 32'(rsp), 32'd2);
        axi_write(6'h20, 32'h0, 4'hF, rsp);
        check("unmapped_wr20_bresp", 32'(rsp), 32'd2);
        rd_check("status_after_unmapped", 6'h04, 32'h2, 2'b00);
        rd_check("ctrl_after_unmapped", 6'h00, 32'h2, 2'b00);
        check("src_ip_after_unmapped", src_ip, 32'hC0A8_0001);

        // Byte strobes and field outputs
        axi_write(6'h10, 32'h1234_5678, 4'b0011, rsp);
        check("src_port_strb", 32'(src_port), 32'h0);
        check("dst_port_strb", 32'(dst_port), 32'h5678);
        rd_check("ports_rb", 6'h10, 32'h0000_5678, 2'b00);
        axi_write(6'h14, 32'hABCD_1234, 4'hF, rsp);
        check("payload_len", 32'(payload_len), 32'h1234);
        rd_check("len_rb", 6'h14, 32'h0000_1234, 2'b00);
        axi_write(6'h0C, 32'h0A00_0002, 4'hF, rsp);
        check("dst_ip", dst_ip, 32'h0A00_0002);

        // Read captured on the same edge as a write commit sees the old value
        s_axi_awaddr = 6'h08; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'h0102_0304; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        tick(1);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_araddr = 6'h08; s_axi_arvalid = 1'b1;
        tick(1);
        s_axi_arvalid = 1'b0;
        check("rd_wr_same_rvalid", 32'(s_axi_rvalid), 32'd1);
        check("rd_wr_same_old", s_axi_rdata, 32'hC0A8_0001);
        check("rd_wr_same_new_reg", src_ip, 32'h0102_0304);
        s_axi_rready = 1'b1; s_axi_bready = 1'b1;
        tick(1);
        s_axi_rready = 1'b0; s_axi_bready = 1'b0;

        // Back-pressured response, then reset mid W_RESP
        s_axi_awaddr = 6'h10; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'hAAAA_BBBB; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        tick(1);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        tick(1);
        for (int i = 0; i < 5; i++) begin
            check("bvalid_hold", 32'(s_axi_bvalid), 32'd1);
            check("awready_in_resp", 32'(s_axi_awready), 32'd0);
            tick(1);
        end
        check("ports_committed", 32'(src_port), 32'hAAAA);
        rst = 1'b1;
        tick(1);
        check("rst_mid_bvalid", 32'(s_axi_bvalid), 32'd0);
        check("rst_mid_awready", 32'(s_axi_awready), 32'd0);
        check("rst_mid_src_ip", src_ip, 32'h0);
        check("rst_mid_dst_ip", dst_ip, 32'h0);
        check("rst_mid_ports", {src_port, dst_port}, 32'h0);
        check("rst_mid_len", 32'(payload_len), 32'h0);
        rst = 1'b0;
        tick(1);
        check("awready_after_rst2", 32'(s_axi_awready), 32'd1);
        check("bvalid_after_rst2", 32'(s_axi_bvalid), 32'd0);
        rd_check("ctrl_after_rst", 6'h00, 32'h0, 2'b00);
        rd_check("status_after_rst", 6'h04, 32'h0, 2'b00);
        rd_check("tx_count_after_rst", 6'h18, 32'h0, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/udp_cfg_axil_slave.md
UDP_CFG_AXIL_SLAVE -- requirements
Module: udp_cfg_axil_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, meaning AXI4-Lite byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning AXI4-Lite data width; only 32 is supported.
REQ-003 SHALL have parameter ID_VALUE, default 32'h5544_5001, meaning the constant returned by the ID register.
REQ-004 SHALL have port clk input 1, the single clock for all logic.
REQ-005 SHALL have port rst input 1, a synchronous active-high reset.
REQ-006 SHALL have write-address ports s_axi_awaddr input ADDR_W, s_axi_awvalid input 1 and s_axi_awready output 1.
REQ-007 SHALL have write-data ports s_axi_wdata input 32, s_axi_wstrb input 4, s_axi_wvalid input 1 and s_axi_wready output 1.
REQ-008 SHALL have write-response ports s_axi_bresp output 2, s_axi_bvalid output 1 and s_axi_bready input 1.
REQ-009 SHALL have read-address ports s_axi_araddr input ADDR_W, s_axi_arvalid input 1 and s_axi_arready output 1.
REQ-010 SHALL have read-data ports s_axi_rdata output 32, s_axi_rresp output 2, s_axi_rvalid output 1 and s_axi_rready input 1.
REQ-011 SHALL have ports tx_start output 1 (one-cycle start pulse), tx_busy input 1 and tx_done input 1 (one-cycle completion pulse).
REQ-012 SHALL have ports src_ip output 32, dst_ip output 32, src_port output 16, dst_port output 16 and payload_len output 16, each driven directly from its register.

Function
REQ-013 Register map, indexed by addr[5:2]: 0x00 CTRL RW (bit0 START, write-1 pulse, reads 0; bit1 ENABLE); 0x04 STATUS (bit0 BUSY = tx_busy, RO; bit1 DONE, sticky, W1C); 0x08 SRC_IP RW; 0x0C DST_IP RW; 0x10 PORTS RW (src[31:16], dst[15:0]); 0x14 LEN RW [15:0]; 0x18 TX_COUNT RO; 0x1C ID RO.
REQ-014 Addresses 0x20-0x3F SHALL return resp SLVERR (2'b10); reads return 0 and writes have no effect. Mapped accesses SHALL return OKAY. addr[1:0] are ignored.
REQ-015 Write FSM states: W_IDLE and W_RESP. In W_IDLE, awready=1 until AW is latched and wready=1 until W is latched; AW and W are accepted in either order or in the same cycle.
REQ-016 The cycle after both AW and W are latched, the register SHALL be updated per wstrb byte lanes and the FSM SHALL enter W_RESP with bvalid=1; bvalid SHALL hold until bready, then return to W_IDLE with awready=wready=0 during W_RESP.
REQ-017 Read FSM states: R_IDLE (arready=1) and R_DATA (rvalid=1, rdata/rresp stable); an AR handshake captures data and moves to R_DATA the next cycle; the rready handshake returns to R_IDLE.
REQ-018 Read and write FSMs SHALL be independent; a read and a write to the same register whose commits coincide SHALL return the pre-write value.
REQ-019 tx_start SHALL pulse for exactly 1 cycle, coincident with the register commit, only when START=1 is written with wstrb[0]=1 and ENABLE=1 (the stored value, or the new value in the same write), and tx_busy=0; otherwise the start is dropped.
REQ-020 tx_done SHALL set DONE and increment TX_COUNT (32-bit, wraps 0xFFFF_FFFF->0). If tx_done and a DONE W1C occur in the same cycle, DONE SHALL remain 1.

Reset
REQ-021 rst SHALL clear all registers, counters, latches and FSMs to W_IDLE/R_IDLE, and drive awready=wready=arready=0 during reset with bvalid=rvalid=tx_start=0 and bresp=rresp=0.
REQ-022 A reset mid-transaction SHALL abandon the transaction with no response issued; ready outputs SHALL reassert the cycle after rst deasserts.

Structure
REQ-023 Shared package udp_pkg SHALL hold the register offsets, field bit positions, the AXI resp encodings (OKAY, SLVERR) and the FSM state enums.
REQ-024 The block SHALL be a single module with no sub-modules.

Verification
REQ-025 AW at t0 with W at t3, write 0xC0A8_0001 to 0x08 -> bvalid at t4 with OKAY; src_ip=0xC0A8_0001; a subsequent read of 0x08 returns it.
REQ-026 Write 0x0000_0003 to CTRL with tx_busy=0 -> tx_start high 1 cycle; with tx_busy=1 -> no pulse; CTRL readback = 0x2.
REQ-027 Pulse tx_done 3 times -> STATUS reads 0x2 and TX_COUNT=3; write 0x2 to STATUS in the same cycle as a tx_done -> DONE still 1.
REQ-028 Read 0x24 -> rresp=SLVERR and rdata=0; write 0x24 -> bresp=SLVERR and no register changed.
REQ-029 Write PORTS=0x1234_5678 with wstrb=4'b0011 -> src_port=0x0000 and dst_port=0x5678.
REQ-030 Hold bready=0 for 5 cycles -> bvalid held and awready=0; assert rst mid-W_RESP -> bvalid=0 the next cycle and all registers return to 0.
